// File: rtl/param_inst_mem_if.sv
// ---------------------------------------------------------------------------
// param_inst_mem_if
//   Bundles the fetch, response and program-load signals of param_inst_mem.
//
//   Fetch     : fetch_req, fetch_addr (byte address), fetch_ready
//   Response  : rsp_valid, rsp_inst, rsp_fault, rsp_stall (consumer hold)
//   Load      : ld_start, ld_valid, ld_data, ld_last, ld_ready, ld_done
//   Status    : mode (00 CLEAR, 01 RUN, 10 LOAD)
//
//   master : the fetch/load client (drives requests and load data)
//   slave  : the instruction memory
// ---------------------------------------------------------------------------
interface param_inst_mem_if #(
    parameter int DATA_W = 32
);
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_inst;
    logic              rsp_fault;
    logic              rsp_stall;
    logic              ld_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              ld_done;
    logic [1:0]        mode;

    modport master (
        output fetch_req, fetch_addr, rsp_stall,
        output ld_start, ld_valid, ld_data, ld_last,
        input  fetch_ready, rsp_valid, rsp_inst, rsp_fault,
        input  ld_ready, ld_done, mode
    );

    modport slave (
        input  fetch_req, fetch_addr, rsp_stall,
        input  ld_start, ld_valid, ld_data, ld_last,
        output fetch_ready, rsp_valid, rsp_inst, rsp_fault,
        output ld_ready, ld_done, mode
    );
endinterface

// File: rtl/param_inst_mem.sv
// ---------------------------------------------------------------------------
// param_inst_mem
//   Loadable instruction memory with a one-cycle-latency fetch port.
//   After reset the whole array is filled with FILL_WORD (CLEAR), then the
//   block serves fetches (RUN). A program can be streamed in starting at
//   word 0 (LOAD); words past the end of the program keep their contents.
//
//   Ports:
//     clk  - sole clock, rising edge
//     rst  - synchronous active-high reset, restarts a full CLEAR
//     bus  - param_inst_mem_if.slave (fetch, response, load, mode)
//
//   Fetch addresses are byte addresses; misaligned or out-of-range
//   addresses are still accepted but answer with rsp_fault=1 and FILL_WORD
//   without touching the array.
// ---------------------------------------------------------------------------
module param_inst_mem #(
    parameter int                ADDR_W    = 6,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(32'h00000013)
) (
    input  logic                clk,
    input  logic                rst,
    param_inst_mem_if.slave     bus
);
    localparam int DEPTH = 1 << ADDR_W;

    // Encodings double as the mode output.
    typedef enum logic [1:0] {
        ST_CLEAR = 2'b00,
        ST_RUN   = 2'b01,
        ST_LOAD  = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_fault_q, rsp_fault_d;
    // Selects the memory read register as the response source; when clear
    // the response word is FILL_WORD (fault) or zero (nothing fetched yet).
    logic               from_mem_q, from_mem_d;
    logic               ld_done_q, ld_done_d;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DATA_W-1:0]  rd_data_q;

    logic               mem_we;
    logic [DATA_W-1:0]  mem_wdata;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_idx;
    logic               addr_fault;
    logic               rsp_hold;
    logic               fetch_ready;
    logic               ld_ready;

    assign rd_idx     = bus.fetch_addr[ADDR_W+1:2];
    assign addr_fault = (bus.fetch_addr[1:0] != 2'b00) ||
                        ((bus.fetch_addr >> (ADDR_W + 2)) != 32'd0);
    assign rsp_hold   = rsp_valid_q && bus.rsp_stall;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rsp_valid_d = 1'b0;
        rsp_fault_d = rsp_fault_q;
        from_mem_d  = from_mem_q;
        ld_done_d   = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = FILL_WORD;
        rd_en       = 1'b0;
        fetch_ready = 1'b0;
        ld_ready    = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                // Pointer wraps to 0 as it leaves the last word.
                if (&ptr_q) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                fetch_ready = !bus.ld_start && !rsp_hold;
                if (rsp_hold) begin
                    rsp_valid_d = 1'b1;
                end else if (bus.ld_start) begin
                    // Load request beats a simultaneous fetch.
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                end else if (bus.fetch_req) begin
                    rsp_valid_d = 1'b1;
                    rsp_fault_d = addr_fault;
                    from_mem_d  = !addr_fault;
                    rd_en       = !addr_fault;
                end
            end

            ST_LOAD: begin
                ld_ready = 1'b1;
                if (bus.ld_valid) begin
                    mem_we    = 1'b1;
                    mem_wdata = bus.ld_data;
                    ptr_d     = ptr_q + 1'b1;
                    if (bus.ld_last || (&ptr_q)) begin
                        state_d   = ST_RUN;
                        ld_done_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            from_mem_q  <= 1'b0;
            ld_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            from_mem_q  <= from_mem_d;
            ld_done_q   <= ld_done_d;
        end
    end

    // Array and its read register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[ptr_q] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en && !rst) begin
            rd_data_q <= mem[rd_idx];
        end
    end

    assign bus.fetch_ready = fetch_ready;
    assign bus.ld_ready    = ld_ready;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_fault   = rsp_fault_q;
    assign bus.rsp_inst    = from_mem_q  ? rd_data_q :
                             rsp_fault_q ? FILL_WORD : '0;
    assign bus.ld_done     = ld_done_q;
    assign bus.mode        = state_q;

endmodule

// File: tb/tb_param_inst_mem.sv
// ---------------------------------------------------------------------------
// tb_param_inst_mem
//   Directed checks of param_inst_mem (ADDR_W=6, DATA_W=32): reset state,
//   CLEAR length, fetch latency, program load, faults, stall hold,
//   load/fetch priority, reset during load, and a full-depth load.
// ---------------------------------------------------------------------------
module tb_param_inst_mem;
    localparam logic [31:0] FILL = 32'h00000013;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    param_inst_mem_if #(.DATA_W(32)) bus ();

    param_inst_mem #(
        .ADDR_W    (6),
        .DATA_W    (32),
        .FILL_WORD (32'h00000013)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted fetch: ready must be high, response appears next cycle.
    task automatic do_fetch(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_inst, input logic exp_fault);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = addr;
        #1;
        check({tag, "_ready"}, {31'd0, bus.fetch_ready}, 32'd1);
        tick();
        bus.fetch_req = 1'b0;
        check({tag, "_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        check({tag, "_inst"},  bus.rsp_inst, exp_inst);
        check({tag, "_fault"}, {31'd0, bus.rsp_fault}, {31'd0, exp_fault});
    endtask

    // Count cycles until RUN, with ld_start optionally held during the
    // first few cycles (it must be ignored in CLEAR).
    task automatic wait_run(input int start_cycles, output int n, output int done_seen);
        n = 0;
        done_seen = 0;
        while (bus.mode !== 2'b01 && n < 200) begin
            bus.ld_start = (n < start_cycles);
            tick();
            n++;
            if (bus.ld_done === 1'b1) done_seen = 1;
        end
        bus.ld_start = 1'b0;
    endtask

    int n;
    int done_seen;
    logic [31:0] prog [3];

    initial begin
        prog[0] = 32'h00200093;
        prog[1] = 32'h00600113;
        prog[2] = 32'h002081B3;

        rst            = 1'b1;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = 32'd0;
        bus.rsp_stall  = 1'b0;
        bus.ld_start   = 1'b0;
        bus.ld_valid   = 1'b0;
        bus.ld_data    = 32'd0;
        bus.ld_last    = 1'b0;

        // Reset state.
        tick();
        rst = 1'b0;
        check("rst_mode",     {30'd0, bus.mode}, 32'd0);
        check("rst_valid",    {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_inst",     bus.rsp_inst, 32'd0);
        check("rst_fault",    {31'd0, bus.rsp_fault}, 32'd0);
        check("rst_fready",   {31'd0, bus.fetch_ready}, 32'd0);
        check("rst_lready",   {31'd0, bus.ld_ready}, 32'd0);
        check("rst_lddone",   {31'd0, bus.ld_done}, 32'd0);

        // CLEAR lasts exactly DEPTH cycles; ld_start is ignored meanwhile.
        wait_run(4, n, done_seen);
        check("clear_cycles", n, 32'd64);
        check("clear_nodone", done_seen, 32'd0);

        do_fetch("f00", 32'h00, FILL, 1'b0);
        do_fetch("f04", 32'h04, FILL, 1'b0);
        do_fetch("ffc", 32'hFC, FILL, 1'b0);
        tick();
        check("idle_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("idle_inst",  bus.rsp_inst, FILL);

        // Three-word program load.
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        check("ld_mode",  {30'd0, bus.mode}, 32'd2);
        check("ld_ready", {31'd0, bus.ld_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = prog[i];
            bus.ld_last  = (i == 2);
            tick();
        end
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        check("ld3_mode", {30'd0, bus.mode}, 32'd1);
        check("ld3_done", {31'd0, bus.ld_done}, 32'd1);
        tick();
        check("ld3_done_off", {31'd0, bus.ld_done}, 32'd0);

        do_fetch("p08", 32'h08, 32'h002081B3, 1'b0);
        do_fetch("p0c", 32'h0C, FILL, 1'b0);
        do_fetch("p00", 32'h00, 32'h00200093, 1'b0);

        // Faults.
        do_fetch("mis06",  32'h06,  FILL, 1'b1);
        do_fetch("oor100", 32'h100, FILL, 1'b1);

        // Stall holds the response for 3 cycles.
        do_fetch("s04", 32'h04, 32'h00600113, 1'b0);
        bus.rsp_stall  = 1'b1;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h08;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_fready", {31'd0, bus.fetch_ready}, 32'd0);
            tick();
            check("stall_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("stall_inst",  bus.rsp_inst, 32'h00600113);
        end
        bus.rsp_stall = 1'b0;
        #1;
        check("rel_fready", {31'd0, bus.fetch_ready}, 32'd1);
        tick();
        bus.fetch_req = 1'b0;
        check("rel_inst", bus.rsp_inst, 32'h002081B3);

        // ld_start beats a simultaneous fetch.
        tick();
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h00;
        bus.ld_start   = 1'b1;
        #1;
        check("prio_fready", {31'd0, bus.fetch_ready}, 32'd0);
        tick();
        bus.fetch_req = 1'b0;
        bus.ld_start  = 1'b0;
        check("prio_mode",  {30'd0, bus.mode}, 32'd2);
        check("prio_valid", {31'd0, bus.rsp_valid}, 32'd0);

        // Two words then reset: full CLEAR, no ld_done.
        for (int i = 0; i < 2; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 32'hDEAD0000 + i;
            tick();
        end
        bus.ld_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstld_mode", {30'd0, bus.mode}, 32'd0);
        check("rstld_done", {31'd0, bus.ld_done}, 32'd0);
        wait_run(0, n, done_seen);
        check("rstld_cycles", n, 32'd64);
        check("rstld_nodone", done_seen, 32'd0);
        do_fetch("rc00", 32'h00, FILL, 1'b0);

        // Full-depth load without ld_last exits on wrap.
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i == 63) check("full_mode63", {30'd0, bus.mode}, 32'd2);
            bus.ld_valid = 1'b1;
            bus.ld_data  = 32'hA0000000 + i;
            tick();
        end
        bus.ld_valid = 1'b0;
        check("full_mode", {30'd0, bus.mode}, 32'd1);
        check("full_done", {31'd0, bus.ld_done}, 32'd1);
        do_fetch("fullfc", 32'hFC, 32'hA000003F, 1'b0);
        do_fetch("full00", 32'h00, 32'hA0000000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
